// File: rtl/mempool_superbank_arbiter_pkg.sv
// Shared types and constants for the superbank arbiter: tile address layout,
// narrow/wide TCDM request and response structs, bank-side payload types.
package mempool_superbank_arbiter_pkg;

    localparam int unsigned DataWidth          = 32;
    localparam int unsigned BeWidth            = DataWidth / 8;
    localparam int unsigned DmaNumWords        = 4;
    localparam int unsigned TCDMAddrMemWidth   = 8;
    localparam int unsigned TileAddrWidth      = TCDMAddrMemWidth + 4;
    localparam int unsigned MetaIdWidth        = 4;
    localparam int unsigned CoreIdWidth        = 3;
    localparam int unsigned IniAddrWidth       = 2;
    localparam int unsigned AmoWidth           = 4;
    localparam int unsigned MaxDmaStallDefault = 8;

    typedef logic [DataWidth-1:0]               data_t;
    typedef logic [BeWidth-1:0]                 strb_t;
    typedef logic [TCDMAddrMemWidth-1:0]        bank_addr_t;
    typedef logic [TileAddrWidth-1:0]           tile_addr_t;
    typedef logic [MetaIdWidth-1:0]             meta_id_t;
    typedef logic [CoreIdWidth-1:0]             core_id_t;
    typedef logic [IniAddrWidth-1:0]            ini_addr_t;
    typedef logic [AmoWidth-1:0]                amo_t;

    typedef struct packed {
        amo_t  amo;
        data_t data;
    } tcdm_payload_t;

    typedef struct packed {
        amo_t                                amo;
        logic [DmaNumWords*DataWidth-1:0]    data;
    } tcdm_dma_payload_t;

    typedef struct packed {
        tile_addr_t    tgt_addr;
        logic          wen;
        strb_t         be;
        tcdm_payload_t wdata;
        meta_id_t      meta_id;
        core_id_t      core_id;
        ini_addr_t     ini_addr;
    } tcdm_slave_req_t;

    typedef struct packed {
        tcdm_payload_t rdata;
        meta_id_t      meta_id;
        core_id_t      core_id;
        ini_addr_t     ini_addr;
    } tcdm_slave_resp_t;

    typedef struct packed {
        tile_addr_t                        tgt_addr;
        logic                              wen;
        logic [DmaNumWords*BeWidth-1:0]    be;
        tcdm_dma_payload_t                 wdata;
        meta_id_t                          meta_id;
        core_id_t                          core_id;
    } tcdm_dma_req_t;

    typedef struct packed {
        tcdm_dma_payload_t rdata;
        meta_id_t          meta_id;
        core_id_t          core_id;
    } tcdm_dma_resp_t;

    // Bank row lives in the top bits of the tile address; the low bits select
    // the bank and are already resolved by the crossbar.
    function automatic bank_addr_t row_of(input tile_addr_t addr);
        return addr[TileAddrWidth-1 -: TCDMAddrMemWidth];
    endfunction

endpackage

// File: rtl/mempool_superbank_arbiter_if.sv
// Bundle of the narrow, wide and bank-side signals around one superbank.
// slave: arbiter view; master: requester/bank-environment view.
interface mempool_superbank_arbiter_if
    import mempool_superbank_arbiter_pkg::*;
#(
    parameter int unsigned NumWords = DmaNumWords
) ();

    tcdm_slave_req_t  [NumWords-1:0] narrow_req;
    logic             [NumWords-1:0] narrow_valid;
    logic             [NumWords-1:0] narrow_ready;
    tcdm_slave_resp_t [NumWords-1:0] narrow_resp;
    logic             [NumWords-1:0] narrow_rvalid;

    tcdm_dma_req_t                   dma_req;
    logic                            dma_valid;
    logic                            dma_ready;
    tcdm_dma_resp_t                  dma_resp;
    logic                            dma_rvalid;

    logic             [NumWords-1:0] bank_req;
    logic             [NumWords-1:0] bank_wen;
    strb_t            [NumWords-1:0] bank_be;
    bank_addr_t       [NumWords-1:0] bank_addr;
    tcdm_payload_t    [NumWords-1:0] bank_wdata;
    data_t            [NumWords-1:0] bank_rdata;

    modport slave (
        input  narrow_req, narrow_valid, dma_req, dma_valid, bank_rdata,
        output narrow_ready, narrow_resp, narrow_rvalid,
        output dma_ready, dma_resp, dma_rvalid,
        output bank_req, bank_wen, bank_be, bank_addr, bank_wdata
    );

    modport master (
        output narrow_req, narrow_valid, dma_req, dma_valid, bank_rdata,
        input  narrow_ready, narrow_resp, narrow_rvalid,
        input  dma_ready, dma_resp, dma_rvalid,
        input  bank_req, bank_wen, bank_be, bank_addr, bank_wdata
    );

endinterface

// File: rtl/mempool_superbank_arbiter.sv
// Superbank arbiter: narrow per-bank requesters win by default; the wide DMA
// port takes all banks at once when no narrow request is pending or when it
// has already lost MaxDmaStall cycles. Banks answer one cycle after the
// request, so responses are steered by the owner registered at grant time.
module mempool_superbank_arbiter
    import mempool_superbank_arbiter_pkg::*;
#(
    parameter int unsigned NumWords    = DmaNumWords,
    parameter int unsigned MaxDmaStall = MaxDmaStallDefault
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    mempool_superbank_arbiter_if.slave  bus
);

    localparam int unsigned StallW   = (MaxDmaStall < 1) ? 1 : $clog2(MaxDmaStall + 1);
    localparam logic [StallW-1:0] StallMax = StallW'(MaxDmaStall);
    localparam int unsigned RowLsbW  = TileAddrWidth - TCDMAddrMemWidth;

    logic [StallW-1:0]         r_stall_cnt;
    logic                      w_stall_hit;
    logic                      w_dma_gnt;
    logic [NumWords-1:0]       w_narrow_gnt;

    logic                      r_dma_q;
    meta_id_t                  r_dma_meta;
    core_id_t                  r_dma_core;
    logic [NumWords-1:0]       r_narrow_q;
    meta_id_t [NumWords-1:0]   r_nar_meta;
    core_id_t [NumWords-1:0]   r_nar_core;
    amo_t     [NumWords-1:0]   r_nar_amo;
    ini_addr_t[NumWords-1:0]   r_nar_ini;
    logic                      w_unused_bits;

    // Grants are held off while reset is asserted so every output reads 0.
    assign w_stall_hit  = (r_stall_cnt == StallMax);
    assign w_dma_gnt    = i_rst_n & bus.dma_valid & (~|bus.narrow_valid | w_stall_hit);
    assign w_narrow_gnt = bus.narrow_valid & {NumWords{i_rst_n & ~w_dma_gnt}};

    assign bus.dma_ready    = w_dma_gnt;
    assign bus.narrow_ready = w_narrow_gnt;

    // Starvation counter: counts lost DMA cycles, saturates, clears on grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_dma_gnt) begin
            r_stall_cnt <= '0;
        end else if (bus.dma_valid && !w_stall_hit) begin
            r_stall_cnt <= r_stall_cnt + StallW'(1);
        end
    end

    // Bank request mux: DMA splits its wide word across banks, narrow passes through.
    always_comb begin
        bus.bank_req = w_dma_gnt ? {NumWords{1'b1}} : w_narrow_gnt;
        for (int i = 0; i < NumWords; i++) begin
            bus.bank_wen[i]   = 1'b0;
            bus.bank_be[i]    = '0;
            bus.bank_addr[i]  = '0;
            bus.bank_wdata[i] = '0;
            if (w_dma_gnt) begin
                bus.bank_wen[i]        = bus.dma_req.wen;
                bus.bank_be[i]         = bus.dma_req.be[i*BeWidth +: BeWidth];
                bus.bank_addr[i]       = row_of(bus.dma_req.tgt_addr);
                bus.bank_wdata[i].data = bus.dma_req.wdata.data[i*DataWidth +: DataWidth];
                bus.bank_wdata[i].amo  = '0;
            end else if (w_narrow_gnt[i]) begin
                bus.bank_wen[i]   = bus.narrow_req[i].wen;
                bus.bank_be[i]    = bus.narrow_req[i].be;
                bus.bank_addr[i]  = row_of(bus.narrow_req[i].tgt_addr);
                bus.bank_wdata[i] = bus.narrow_req[i].wdata;
            end
        end
    end

    // Capture response ownership and echo fields at acceptance time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dma_q    <= 1'b0;
            r_dma_meta <= '0;
            r_dma_core <= '0;
            r_narrow_q <= '0;
            r_nar_meta <= '0;
            r_nar_core <= '0;
            r_nar_amo  <= '0;
            r_nar_ini  <= '0;
        end else begin
            r_dma_q    <= w_dma_gnt;
            r_narrow_q <= w_narrow_gnt;
            if (w_dma_gnt) begin
                r_dma_meta <= bus.dma_req.meta_id;
                r_dma_core <= bus.dma_req.core_id;
            end
            for (int i = 0; i < NumWords; i++) begin
                if (w_narrow_gnt[i]) begin
                    r_nar_meta[i] <= bus.narrow_req[i].meta_id;
                    r_nar_core[i] <= bus.narrow_req[i].core_id;
                    r_nar_amo[i]  <= bus.narrow_req[i].wdata.amo;
                    r_nar_ini[i]  <= bus.narrow_req[i].ini_addr;
                end
            end
        end
    end

    // Response steering; outputs stay 0 whenever the matching rvalid is low.
    always_comb begin
        bus.dma_rvalid    = r_dma_q;
        bus.dma_resp      = '0;
        bus.narrow_rvalid = r_narrow_q;
        bus.narrow_resp   = '0;
        if (r_dma_q) begin
            bus.dma_resp.rdata.data = bus.bank_rdata;
            bus.dma_resp.meta_id    = r_dma_meta;
            bus.dma_resp.core_id    = r_dma_core;
        end
        for (int i = 0; i < NumWords; i++) begin
            if (r_narrow_q[i]) begin
                bus.narrow_resp[i].rdata.data = bus.bank_rdata[i];
                bus.narrow_resp[i].rdata.amo  = r_nar_amo[i];
                bus.narrow_resp[i].meta_id    = r_nar_meta[i];
                bus.narrow_resp[i].core_id    = r_nar_core[i];
                bus.narrow_resp[i].ini_addr   = r_nar_ini[i];
            end
        end
    end

    // Bank-select address bits and the DMA amo field have no use inside a superbank.
    always_comb begin
        w_unused_bits = ^{bus.dma_req.tgt_addr[RowLsbW-1:0], bus.dma_req.wdata.amo};
        for (int i = 0; i < NumWords; i++) begin
            w_unused_bits = w_unused_bits ^ (^bus.narrow_req[i].tgt_addr[RowLsbW-1:0]);
        end
    end

    // The wide grant and any narrow acceptance are mutually exclusive.
    a_dma_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_dma_gnt |-> (bus.narrow_ready == '0));

endmodule

// File: tb/tb_mempool_superbank_arbiter.sv
// Directed bench for the superbank arbiter with a one-cycle-latency bank model.
module tb_mempool_superbank_arbiter;
    import mempool_superbank_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mempool_superbank_arbiter_if #(.NumWords(4)) bus0 ();
    mempool_superbank_arbiter_if #(.NumWords(4)) bus1 ();

    mempool_superbank_arbiter #(.NumWords(4), .MaxDmaStall(8)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0.slave)
    );

    mempool_superbank_arbiter #(.NumWords(4), .MaxDmaStall(0)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: read-before-write, data returned one cycle after bank_req.
    logic [31:0] mem [4][256];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus0.bank_req[b]) begin
                bus0.bank_rdata[b] <= mem[b][bus0.bank_addr[b]];
                if (bus0.bank_wen[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (bus0.bank_be[b][k])
                            mem[b][bus0.bank_addr[b]][k*8 +: 8] <= bus0.bank_wdata[b].data[k*8 +: 8];
                end
            end
        end
    end

    task automatic idle();
        bus0.narrow_valid = '0;
        bus0.dma_valid    = 1'b0;
        bus1.narrow_valid = '0;
        bus1.dma_valid    = 1'b0;
    endtask

    task automatic test_reset();
        bus0.narrow_req = '0;
        bus0.dma_req    = '0;
        bus1.narrow_req = '0;
        bus1.dma_req    = '0;
        bus1.bank_rdata = '0;
        idle();
        rst_n = 1'b0;
        bus0.dma_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.dma_ready !== 1'b0) begin errors++; $display("FAIL reset_dma_ready got %b exp 0", bus0.dma_ready); end
        checks++; if (bus0.bank_req !== 4'h0) begin errors++; $display("FAIL reset_bank_req got %h exp 0", bus0.bank_req); end
        checks++; if (bus0.narrow_rvalid !== 4'h0 || bus0.dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b/%b exp 0", bus0.narrow_rvalid, bus0.dma_rvalid); end
        checks++; if (int'(dut0.r_stall_cnt) !== 0) begin errors++; $display("FAIL reset_stall got %0d exp 0", dut0.r_stall_cnt); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_dma_write();
        logic [31:0] exp_w [4];
        exp_w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        @(posedge clk); #1;
        bus0.dma_req = '0;
        bus0.dma_req.tgt_addr   = {8'd5, 4'd0};
        bus0.dma_req.wen        = 1'b1;
        bus0.dma_req.be         = 16'hFFFF;
        bus0.dma_req.wdata.data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        bus0.dma_req.wdata.amo  = 4'hF;
        bus0.dma_req.meta_id    = 4'hA;
        bus0.dma_req.core_id    = 3'd2;
        bus0.dma_valid = 1'b1;
        #1;
        checks++; if (bus0.dma_ready !== 1'b1) begin errors++; $display("FAIL dmaw_ready got %b exp 1", bus0.dma_ready); end
        checks++; if (bus0.bank_req !== 4'hF || bus0.bank_wen !== 4'hF) begin errors++; $display("FAIL dmaw_req_wen got %h/%h exp f/f", bus0.bank_req, bus0.bank_wen); end
        checks++; if (bus0.bank_be !== 16'hFFFF) begin errors++; $display("FAIL dmaw_be got %h exp ffff", bus0.bank_be); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus0.bank_addr[i] !== 8'd5) begin errors++; $display("FAIL dmaw_addr%0d got %0d exp 5", i, bus0.bank_addr[i]); end
            checks++; if (bus0.bank_wdata[i].data !== exp_w[i]) begin errors++; $display("FAIL dmaw_data%0d got %h exp %h", i, bus0.bank_wdata[i].data, exp_w[i]); end
            checks++; if (bus0.bank_wdata[i].amo !== 4'h0) begin errors++; $display("FAIL dmaw_amo%0d got %h exp 0", i, bus0.bank_wdata[i].amo); end
        end
        @(posedge clk); #1;
        idle();
        checks++; if (bus0.dma_rvalid !== 1'b1) begin errors++; $display("FAIL dmaw_rvalid got %b exp 1", bus0.dma_rvalid); end
        checks++; if (bus0.dma_resp.meta_id !== 4'hA || bus0.dma_resp.core_id !== 3'd2) begin errors++; $display("FAIL dmaw_echo got %h/%h exp a/2", bus0.dma_resp.meta_id, bus0.dma_resp.core_id); end
        @(posedge clk); #1;
        checks++; if (bus0.dma_rvalid !== 1'b0) begin errors++; $display("FAIL dmaw_single_rvalid got %b exp 0", bus0.dma_rvalid); end
    endtask

    task automatic test_narrow_read();
        @(posedge clk); #1;
        bus0.narrow_req[1] = '0;
        bus0.narrow_req[1].tgt_addr = {8'd5, 4'd1};
        bus0.narrow_req[1].meta_id  = 4'd3;
        bus0.narrow_req[1].core_id  = 3'd1;
        bus0.narrow_req[1].ini_addr = 2'd3;
        bus0.narrow_valid = 4'b0010;
        #1;
        checks++; if (bus0.narrow_ready !== 4'b0010 || bus0.bank_req !== 4'b0010) begin errors++; $display("FAIL nrd_grant got %b/%b exp 0010", bus0.narrow_ready, bus0.bank_req); end
        checks++; if (bus0.bank_addr[1] !== 8'd5 || bus0.bank_wen !== 4'b0000) begin errors++; $display("FAIL nrd_addr got %0d/%b exp 5/0000", bus0.bank_addr[1], bus0.bank_wen); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus0.narrow_rvalid !== 4'b0010) begin errors++; $display("FAIL nrd_rvalid got %b exp 0010", bus0.narrow_rvalid); end
        checks++; if (bus0.narrow_resp[1].rdata.data !== 32'h2222_2222) begin errors++; $display("FAIL nrd_data got %h exp 22222222", bus0.narrow_resp[1].rdata.data); end
        checks++; if (bus0.narrow_resp[1].ini_addr !== 2'd3 || bus0.narrow_resp[1].meta_id !== 4'd3 || bus0.narrow_resp[1].core_id !== 3'd1) begin
            errors++; $display("FAIL nrd_echo got %0d/%0d/%0d exp 3/3/1", bus0.narrow_resp[1].ini_addr, bus0.narrow_resp[1].meta_id, bus0.narrow_resp[1].core_id); end
    endtask

    task automatic test_all_narrow();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus0.narrow_req[i] = '0;
            bus0.narrow_req[i].tgt_addr   = {8'(i + 1), 4'(i)};
            bus0.narrow_req[i].wen        = (i % 2 == 0);
            bus0.narrow_req[i].be         = 4'hF;
            bus0.narrow_req[i].wdata.data = 32'hA0 + 32'(i);
            bus0.narrow_req[i].wdata.amo  = 4'(i + 1);
            bus0.narrow_req[i].meta_id    = 4'(i + 4);
            bus0.narrow_req[i].core_id    = 3'(i);
            bus0.narrow_req[i].ini_addr   = 2'(i);
        end
        bus0.narrow_valid = 4'hF;
        #1;
        checks++; if (bus0.narrow_ready !== 4'hF || bus0.dma_ready !== 1'b0) begin errors++; $display("FAIL all_grant got %h/%b exp f/0", bus0.narrow_ready, bus0.dma_ready); end
        checks++; if (bus0.bank_req !== 4'hF || bus0.bank_wen !== 4'b0101) begin errors++; $display("FAIL all_req_wen got %h/%b exp f/0101", bus0.bank_req, bus0.bank_wen); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus0.bank_addr[i] !== 8'(i + 1) || bus0.bank_wdata[i].amo !== 4'(i + 1)) begin
                errors++; $display("FAIL all_map%0d got %0d/%h exp %0d/%h", i, bus0.bank_addr[i], bus0.bank_wdata[i].amo, i + 1, i + 1); end
        end
        @(posedge clk); #1;
        idle();
        checks++; if (bus0.narrow_rvalid !== 4'hF) begin errors++; $display("FAIL all_rvalid got %h exp f", bus0.narrow_rvalid); end
        checks++; if (bus0.narrow_resp[3].meta_id !== 4'd7 || bus0.narrow_resp[2].rdata.amo !== 4'd3 || bus0.narrow_resp[1].ini_addr !== 2'd1) begin
            errors++; $display("FAIL all_echo got %0d/%0d/%0d exp 7/3/1", bus0.narrow_resp[3].meta_id, bus0.narrow_resp[2].rdata.amo, bus0.narrow_resp[1].ini_addr); end
        checks++; if (int'(dut0.r_stall_cnt) !== 0) begin errors++; $display("FAIL all_stall got %0d exp 0", dut0.r_stall_cnt); end
    endtask

    task automatic test_dma_starve();
        @(posedge clk); #1;
        bus0.narrow_req[2] = '0;
        bus0.narrow_req[2].tgt_addr = {8'd7, 4'd2};
        bus0.narrow_valid = 4'b0100;
        bus0.dma_req = '0;
        bus0.dma_req.tgt_addr = {8'd5, 4'd0};
        bus0.dma_req.meta_id  = 4'h5;
        bus0.dma_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (bus0.dma_ready !== 1'b0 || bus0.narrow_ready !== 4'b0100 || int'(dut0.r_stall_cnt) !== c) begin
                errors++; $display("FAIL starve_c%0d got %b/%b/%0d exp 0/0100/%0d", c, bus0.dma_ready, bus0.narrow_ready, dut0.r_stall_cnt, c); end
            @(posedge clk); #1;
        end
        #1;
        checks++; if (bus0.dma_ready !== 1'b1 || bus0.narrow_ready !== 4'b0000 || bus0.bank_req !== 4'hF) begin
            errors++; $display("FAIL starve_force got %b/%b/%h exp 1/0000/f", bus0.dma_ready, bus0.narrow_ready, bus0.bank_req); end
        checks++; if (int'(dut0.r_stall_cnt) !== 8) begin errors++; $display("FAIL starve_sat got %0d exp 8", dut0.r_stall_cnt); end
        @(posedge clk); #1;
        bus0.dma_valid = 1'b0;
        checks++; if (int'(dut0.r_stall_cnt) !== 0) begin errors++; $display("FAIL starve_clear got %0d exp 0", dut0.r_stall_cnt); end
        checks++; if (bus0.dma_rvalid !== 1'b1 || bus0.narrow_rvalid !== 4'b0000 || bus0.dma_resp.meta_id !== 4'h5) begin
            errors++; $display("FAIL starve_resp got %b/%b/%h exp 1/0000/5", bus0.dma_rvalid, bus0.narrow_rvalid, bus0.dma_resp.meta_id); end
        checks++; if (bus0.dma_resp.rdata.data !== 128'h4444_4444_3333_3333_2222_2222_1111_1111) begin
            errors++; $display("FAIL starve_rdata got %h exp 44..33..22..11", bus0.dma_resp.rdata.data); end
        #1;
        checks++; if (bus0.narrow_ready !== 4'b0100) begin errors++; $display("FAIL starve_resume got %b exp 0100", bus0.narrow_ready); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_stall_hold();
        @(posedge clk); #1;
        bus0.narrow_req[0] = '0;
        bus0.narrow_valid = 4'b0001;
        bus0.dma_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus0.dma_valid = 1'b0;
        checks++; if (int'(dut0.r_stall_cnt) !== 3) begin errors++; $display("FAIL hold_count got %0d exp 3", dut0.r_stall_cnt); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (int'(dut0.r_stall_cnt) !== 3) begin errors++; $display("FAIL hold_keep got %0d exp 3", dut0.r_stall_cnt); end
        bus0.narrow_valid = 4'b0000;
        bus0.dma_valid = 1'b1;
        #1;
        checks++; if (bus0.dma_ready !== 1'b1) begin errors++; $display("FAIL hold_free_gnt got %b exp 1", bus0.dma_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (int'(dut0.r_stall_cnt) !== 0) begin errors++; $display("FAIL hold_clear got %0d exp 0", dut0.r_stall_cnt); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        bus0.narrow_req[0] = '0;
        bus0.narrow_req[0].tgt_addr   = {8'd9, 4'd0};
        bus0.narrow_req[0].wen        = 1'b1;
        bus0.narrow_req[0].be         = 4'hF;
        bus0.narrow_req[0].wdata.data = 32'hCAFE_F00D;
        bus0.narrow_valid = 4'b0001;
        #1;
        checks++; if (bus0.narrow_ready !== 4'b0001) begin errors++; $display("FAIL b2b_wr_ready got %b exp 0001", bus0.narrow_ready); end
        @(posedge clk); #1;
        bus0.narrow_req[0].wen     = 1'b0;
        bus0.narrow_req[0].meta_id = 4'd2;
        #1;
        checks++; if (bus0.narrow_ready !== 4'b0001 || bus0.narrow_rvalid !== 4'b0001) begin
            errors++; $display("FAIL b2b_rd_ready got %b/%b exp 0001/0001", bus0.narrow_ready, bus0.narrow_rvalid); end
        @(posedge clk); #1;
        bus0.narrow_valid = 4'b0000;
        bus0.dma_req = '0;
        bus0.dma_req.tgt_addr = {8'd5, 4'd0};
        bus0.dma_req.meta_id  = 4'd6;
        bus0.dma_valid = 1'b1;
        checks++; if (bus0.narrow_rvalid !== 4'b0001 || bus0.narrow_resp[0].rdata.data !== 32'hCAFE_F00D || bus0.narrow_resp[0].meta_id !== 4'd2) begin
            errors++; $display("FAIL b2b_rd_data got %b/%h/%0d exp 0001/cafef00d/2", bus0.narrow_rvalid, bus0.narrow_resp[0].rdata.data, bus0.narrow_resp[0].meta_id); end
        @(posedge clk); #1;
        bus0.dma_req.meta_id = 4'd7;
        #1;
        checks++; if (bus0.dma_ready !== 1'b1 || bus0.dma_rvalid !== 1'b1 || bus0.dma_resp.meta_id !== 4'd6) begin
            errors++; $display("FAIL b2b_dma1 got %b/%b/%0d exp 1/1/6", bus0.dma_ready, bus0.dma_rvalid, bus0.dma_resp.meta_id); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus0.dma_rvalid !== 1'b1 || bus0.dma_resp.meta_id !== 4'd7 || bus0.dma_resp.rdata.data[63:32] !== 32'h2222_2222) begin
            errors++; $display("FAIL b2b_dma2 got %b/%0d/%h exp 1/7/22222222", bus0.dma_rvalid, bus0.dma_resp.meta_id, bus0.dma_resp.rdata.data[63:32]); end
    endtask

    task automatic test_zero_stall();
        @(posedge clk); #1;
        bus1.narrow_valid = 4'hF;
        bus1.dma_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus1.dma_ready !== 1'b1 || bus1.narrow_ready !== 4'h0) begin
                errors++; $display("FAIL zero_c%0d got %b/%h exp 1/0", c, bus1.dma_ready, bus1.narrow_ready); end
            @(posedge clk); #1;
        end
        bus1.dma_valid = 1'b0;
        #1;
        checks++; if (bus1.narrow_ready !== 4'hF || bus1.dma_rvalid !== 1'b1) begin
            errors++; $display("FAIL zero_release got %h/%b exp f/1", bus1.narrow_ready, bus1.dma_rvalid); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus0.narrow_req[0] = '0;
        bus0.narrow_valid = 4'b0001;
        bus0.dma_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (int'(dut0.r_stall_cnt) !== 3 || bus0.narrow_rvalid !== 4'b0001) begin
            errors++; $display("FAIL rstmid_pre got %0d/%b exp 3/0001", dut0.r_stall_cnt, bus0.narrow_rvalid); end
        rst_n = 1'b0;
        idle();
        #1;
        checks++; if (int'(dut0.r_stall_cnt) !== 0 || bus0.narrow_rvalid !== 4'b0000 || bus0.bank_req !== 4'h0) begin
            errors++; $display("FAIL rstmid_a got %0d/%b/%h exp 0/0/0", dut0.r_stall_cnt, bus0.narrow_rvalid, bus0.bank_req); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus0.dma_req = '0;
        bus0.dma_req.tgt_addr = {8'd10, 4'd0};
        bus0.dma_req.wen      = 1'b1;
        bus0.dma_req.meta_id  = 4'hC;
        bus0.dma_valid = 1'b1;
        #1;
        checks++; if (bus0.dma_ready !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", bus0.dma_ready); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle();
        #1;
        checks++; if (bus0.dma_rvalid !== 1'b0 || bus0.dma_resp !== '0 || bus0.dma_ready !== 1'b0 || bus0.narrow_ready !== 4'h0 || bus0.bank_req !== 4'h0) begin
            errors++; $display("FAIL rstmid_b got %b/%b/%h exp 0/0/0", bus0.dma_rvalid, bus0.dma_ready, bus0.bank_req); end
        checks++; if (int'(dut0.r_stall_cnt) !== 0) begin errors++; $display("FAIL rstmid_stall got %0d exp 0", dut0.r_stall_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (bus0.dma_rvalid !== 1'b0 || bus0.narrow_rvalid !== 4'h0) begin
                errors++; $display("FAIL rstmid_post%0d got %b/%b exp 0/0", c, bus0.dma_rvalid, bus0.narrow_rvalid); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dma_write();
        test_narrow_read();
        test_all_narrow();
        test_dma_starve();
        test_stall_hold();
        test_back_to_back();
        test_zero_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
